// File: rtl/muldiv_ctrl.sv
// Iterative MIPS multiply/divide sequencer with its HI/LO register pair and ID-stage stall.
// Optional MULDIV_MTHILO_EN adds MTHI/MTLO write-back ports that write or abort into HI/LO.
module muldiv_ctrl #(
    parameter int ITER  = 32,
    parameter int CNT_W = 6
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        Start_id,
    input  logic [1:0]  Op_id,
    input  logic [31:0] RsData_id,
    input  logic [31:0] RtData_id,
    input  logic        HiLoRead_id,
    input  logic        Stall_in,
`ifdef MULDIV_MTHILO_EN
    input  logic        Mthi_wb,
    input  logic        Mtlo_wb,
    input  logic [31:0] RegWriteData_wb,
`endif
    output logic        Stall_md,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] Hi,
    output logic [31:0] Lo
);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_FIX} state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  count;
    logic [63:0]       pair;      // {acc,mplier} or {rem,quot}
    logic [31:0]       opnd;      // multiplicand or divisor magnitude
    logic [31:0]       dividend;
    logic              sign_a, sign_b, is_div, div_zero;
    logic              busy_q, done_q;
    logic [31:0]       hi_q, lo_q;

    logic              wr_hi, wr_lo, wr_any;
    logic [31:0]       wr_data;

`ifdef MULDIV_MTHILO_EN
    assign wr_hi   = Mthi_wb;
    assign wr_lo   = Mtlo_wb;
    assign wr_data = RegWriteData_wb;
`else
    assign wr_hi   = 1'b0;
    assign wr_lo   = 1'b0;
    assign wr_data = 32'd0;
`endif
    assign wr_any = wr_hi | wr_lo;

    logic        accept, signed_op;
    logic [31:0] abs_rs, abs_rt;

    assign accept    = (state == S_IDLE) && Start_id && !Stall_in;
    assign signed_op = !Op_id[0];
    assign abs_rs    = (signed_op && RsData_id[31]) ? (32'd0 - RsData_id) : RsData_id;
    assign abs_rt    = (signed_op && RtData_id[31]) ? (32'd0 - RtData_id) : RtData_id;

    // One shift-add step; the 33-bit sum keeps the carry that shifts into acc.
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    assign mul_sum  = {1'b0, pair[63:32]} + (pair[0] ? {1'b0, opnd} : 33'd0);
    assign mul_next = {mul_sum, pair[31:1]};

    // One restoring step; the shifted remainder needs 33 bits before the compare.
    logic [64:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [63:0] div_next;
    assign div_shift = {pair, 1'b0};
    assign div_ge    = div_shift[64:32] >= {1'b0, opnd};
    assign div_diff  = div_shift[64:32] - {1'b0, opnd};
    assign div_next  = div_ge ? {div_diff[31:0], div_shift[31:1], 1'b1} : div_shift[63:0];

    logic [63:0] prod_fix;
    logic [31:0] fix_hi, fix_lo;
    always_comb begin
        prod_fix = (sign_a ^ sign_b) ? (64'd0 - pair) : pair;
        fix_hi   = prod_fix[63:32];
        fix_lo   = prod_fix[31:0];
        if (is_div) begin
            if (div_zero) begin
                fix_hi = dividend;
                fix_lo = 32'hFFFF_FFFF;
            end else begin
                fix_hi = sign_a ? (32'd0 - pair[63:32]) : pair[63:32];
                fix_lo = (sign_a ^ sign_b) ? (32'd0 - pair[31:0]) : pair[31:0];
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: if (accept) next_state = Op_id[1] ? S_DIV : S_MUL;
            S_MUL, S_DIV: begin
                if (wr_any)              next_state = S_IDLE;
                else if (count == '0)    next_state = S_FIX;
            end
            S_FIX:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            count    <= '0;
            pair     <= '0;
            opnd     <= '0;
            dividend <= '0;
            sign_a   <= 1'b0;
            sign_b   <= 1'b0;
            is_div   <= 1'b0;
            div_zero <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state  <= next_state;
            busy_q <= (next_state != S_IDLE);
            done_q <= (next_state == S_FIX);
            case (state)
                S_IDLE: if (accept) begin
                    sign_a   <= signed_op & RsData_id[31];
                    sign_b   <= signed_op & RtData_id[31];
                    is_div   <= Op_id[1];
                    div_zero <= (RtData_id == 32'd0);
                    dividend <= RsData_id;
                    count    <= CNT_W'(ITER - 1);
                    pair     <= {32'd0, Op_id[1] ? abs_rs : abs_rt};
                    opnd     <= Op_id[1] ? abs_rt : abs_rs;
                end
                S_MUL: begin
                    pair <= mul_next;
                    if (count != '0) count <= count - 1'b1;
                end
                S_DIV: begin
                    pair <= div_next;
                    if (count != '0) count <= count - 1'b1;
                end
                default: ;
            endcase
            if (wr_hi)               hi_q <= wr_data;
            else if (state == S_FIX) hi_q <= fix_hi;
            if (wr_lo)               lo_q <= wr_data;
            else if (state == S_FIX) lo_q <= fix_lo;
        end
    end

    assign Busy     = busy_q;
    assign Done     = done_q;
    assign Hi       = hi_q;
    assign Lo       = lo_q;
    assign Stall_md = busy_q && (HiLoRead_id || Start_id);

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: directed vector table, hand-written stall/reset
// sequences, and random operations checked against an arithmetic reference model.
module tb_muldiv_ctrl;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        Start_id;
  logic [1:0]  Op_id;
  logic [31:0] RsData_id, RtData_id;
  logic        HiLoRead_id, Stall_in;
  logic        Stall_md, Busy, Done;
  logic [31:0] Hi, Lo;
`ifdef MULDIV_MTHILO_EN
  logic        Mthi_wb, Mtlo_wb;
  logic [31:0] RegWriteData_wb;
`endif

  int errors = 0;
  int checks = 0;

  muldiv_ctrl dut (
    .clk(clk), .rst_n(rst_n), .Start_id(Start_id), .Op_id(Op_id),
    .RsData_id(RsData_id), .RtData_id(RtData_id), .HiLoRead_id(HiLoRead_id),
    .Stall_in(Stall_in),
`ifdef MULDIV_MTHILO_EN
    .Mthi_wb(Mthi_wb), .Mtlo_wb(Mtlo_wb), .RegWriteData_wb(RegWriteData_wb),
`endif
    .Stall_md(Stall_md), .Busy(Busy), .Done(Done), .Hi(Hi), .Lo(Lo)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, exp_hi, exp_lo;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: plain signed/unsigned 64-bit arithmetic with the divide-by-zero rule.
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo);
    longint sa, sb, ua, ub;
    logic [63:0] r, q;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = longint'({32'd0, a});
    ub = longint'({32'd0, b});
    hi = 32'd0;
    lo = 32'd0;
    if (!op[1]) begin
      r = op[0] ? 64'(ua * ub) : 64'(sa * sb);
      hi = r[63:32];
      lo = r[31:0];
    end else if (b == 32'd0) begin
      hi = a;
      lo = 32'hFFFF_FFFF;
    end else begin
      q = op[0] ? 64'(ua / ub) : 64'(sa / sb);
      r = op[0] ? 64'(ua % ub) : 64'(sa % sb);
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] eh, input logic [31:0] el, input string tag);
    int k;
    logic seen;
    Start_id = 1'b1; Op_id = op; RsData_id = a; RtData_id = b;
    tick();
    Start_id = 1'b0; RsData_id = $urandom; RtData_id = $urandom;
    check({tag, " busy_after_accept"}, 64'(Busy), 64'd1);
    k = 0;
    seen = 1'b0;
    while (!seen && k < 40) begin
      tick();
      k++;
      seen = Done;
    end
    check({tag, " done_latency"}, 64'(k), 64'd32);
    tick();
    check({tag, " busy_after_done"}, 64'(Busy), 64'd0);
    check({tag, " done_single"}, 64'(Done), 64'd0);
    check({tag, " hi"}, 64'(Hi), 64'(eh));
    check({tag, " lo"}, 64'(Lo), 64'(el));
  endtask

  vec_t vecs[9];

  initial begin
    int stall_cnt, done_cnt;
    logic [31:0] mh, ml, a, b, hold_hi;
    logic [1:0] op;

    vecs[0] = '{2'b00, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA};
    vecs[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[2] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[3] = '{2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[4] = '{2'b11, 32'h1234_5678, 32'h0000_0000, 32'h1234_5678, 32'hFFFF_FFFF};
    vecs[5] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6] = '{2'b10, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD};
    vecs[7] = '{2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[8] = '{2'b10, 32'hFFFF_FFF9, 32'h0000_0000, 32'hFFFF_FFF9, 32'hFFFF_FFFF};

    rst_n = 1'b0; Start_id = 1'b0; Op_id = 2'b00; RsData_id = '0; RtData_id = '0;
    HiLoRead_id = 1'b0; Stall_in = 1'b0;
`ifdef MULDIV_MTHILO_EN
    Mthi_wb = 1'b0; Mtlo_wb = 1'b0; RegWriteData_wb = '0;
`endif
    tick();
    tick();
    check("reset busy", 64'(Busy), 64'd0);
    check("reset done", 64'(Done), 64'd0);
    check("reset hi", 64'(Hi), 64'd0);
    check("reset lo", 64'(Lo), 64'd0);
    check("reset stall", 64'(Stall_md), 64'd0);
    rst_n = 1'b1;
    tick();

    for (int i = 0; i < 9; i++)
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp_hi, vecs[i].exp_lo, $sformatf("vec%0d", i));

    // Dependent MFHI/MFLO held in ID for the whole operation.
    Start_id = 1'b1; Op_id = 2'b00; RsData_id = 32'd3; RtData_id = 32'd5;
    tick();
    Start_id = 1'b0; HiLoRead_id = 1'b1;
    stall_cnt = 0;
    for (int k = 0; k <= 33; k++) begin
      if (k > 0) tick();
      if (Stall_md) stall_cnt++;
      if (k == 32) check("mfhi done_at_32", 64'(Done), 64'd1);
    end
    check("mfhi stall_cycles", 64'(stall_cnt), 64'd33);
    check("mfhi stall_released", 64'(Stall_md), 64'd0);
    check("mfhi lo_new", 64'(Lo), 64'd15);
    HiLoRead_id = 1'b0;
    tick();

    // Back-to-back ops: the second is held in ID and accepted on the first IDLE cycle.
    Start_id = 1'b1; Op_id = 2'b01; RsData_id = 32'd5; RtData_id = 32'd6;
    tick();
    Op_id = 2'b11; RsData_id = 32'd100; RtData_id = 32'd7;
    check("b2b stall", 64'(Stall_md), 64'd1);
    for (int k = 1; k <= 33; k++) tick();
    check("b2b first_idle_busy", 64'(Busy), 64'd0);
    check("b2b first_lo", 64'(Lo), 64'd30);
    check("b2b stall_idle", 64'(Stall_md), 64'd0);
    tick();
    Start_id = 1'b0;
    check("b2b second_accepted", 64'(Busy), 64'd1);
    done_cnt = 0;
    for (int k = 1; k <= 33; k++) begin
      tick();
      if (Done) done_cnt++;
    end
    check("b2b second_done", 64'(done_cnt), 64'd1);
    check("b2b second_hi", 64'(Hi), 64'd2);
    check("b2b second_lo", 64'(Lo), 64'd14);

    // Start while the load-use stall is active is ignored.
    Start_id = 1'b1; Stall_in = 1'b1; Op_id = 2'b00; RsData_id = 32'd9; RtData_id = 32'd9;
    for (int k = 0; k < 3; k++) begin
      tick();
      check($sformatf("stall_in no_accept%0d", k), 64'(Busy), 64'd0);
    end
    Start_id = 1'b0; Stall_in = 1'b0;
    tick();
    check("stall_in hi_unchanged", 64'(Hi), 64'd2);

    // Synchronous reset mid-operation.
    Start_id = 1'b1; Op_id = 2'b00; RsData_id = 32'd1000; RtData_id = 32'd1000;
    tick();
    Start_id = 1'b0;
    for (int k = 0; k < 10; k++) tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midreset busy", 64'(Busy), 64'd0);
    check("midreset hi", 64'(Hi), 64'd0);
    check("midreset lo", 64'(Lo), 64'd0);
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (Done) done_cnt++;
      tick();
    end
    check("midreset no_done", 64'(done_cnt), 64'd0);

`ifdef MULDIV_MTHILO_EN
    run_op(2'b01, 32'd7, 32'd11, 32'd0, 32'd77, "pre_mtlo");
    hold_hi = Hi;
    Start_id = 1'b1; Op_id = 2'b00; RsData_id = 32'd3; RtData_id = 32'd4;
    tick();
    Start_id = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    Mtlo_wb = 1'b1; RegWriteData_wb = 32'hA5A5_A5A5;
    tick();
    Mtlo_wb = 1'b0;
    check("mtlo abort_busy", 64'(Busy), 64'd0);
    check("mtlo lo", 64'(Lo), 64'hA5A5_A5A5);
    check("mtlo hi_kept", 64'(Hi), 64'(hold_hi));
    done_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      if (Done) done_cnt++;
      tick();
    end
    check("mtlo no_done", 64'(done_cnt), 64'd0);
`else
    hold_hi = 32'd0;
`endif

    // Random operations against the reference model.
    for (int i = 0; i < 30; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0:       begin a = $urandom; b = 32'($urandom_range(0, 15)); end
        1:       begin a = 32'($urandom_range(0, 1000)); b = $urandom; end
        default: begin a = $urandom; b = $urandom; end
      endcase
      model(op, a, b, mh, ml);
      run_op(op, a, b, mh, ml, $sformatf("rnd%0d op%0d", i, op));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
